pipe_stall_ctrl: RTL and testbench

// - Central stall/flush sequencer for the 5-stage pipeline (F/D/X/M/W).
// - Consumes decode-stage source registers, X-stage destination and load info,

---
 rtl/pipe_stall_ctrl_pkg.sv | 68 ++++++
 rtl/pipe_stall_ctrl_sat_counter.sv | 41 ++++
 rtl/pipe_stall_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl_pkg
//
// Purpose : shared definitions for the pipeline stall/flush sequencer.
//           Holds the sequencer state encoding, the default register-address
//           width and a bundle type for the per-stage control outputs, plus
//           helper functions that build the recurring control patterns.
//
// Contents:
//   stall_state_e  - RUN / LD_STALL / MEM_WAIT / HALT (2-bit encoding)
//   REG_AW_DEF     - default register-address width (rd / rs fields)
//   stage_ctrl_t   - packed bundle of enables, bubble and flush
//   ctrl_advance() - every stage moves forward
//   ctrl_stop()    - every stage holds, nothing injected
//   ctrl_hold()    - front end holds, a bubble enters D/X, back end drains
//   ctrl_flush()   - every stage moves, the wrong-path F/D and D/X are killed
// ---------------------------------------------------------------------------
package pipe_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    HALT     = 2'd3
  } stall_state_e;

  localparam int REG_AW_DEF = 5;

  typedef struct packed {
    logic pc_en;
    logic fd_en;
    logic dx_en;
    logic xm_en;
    logic mw_en;
    logic dx_bubble;
    logic fd_flush;
  } stage_ctrl_t;

  function automatic stage_ctrl_t ctrl_advance();
    stage_ctrl_t c;
    c = '{pc_en: 1'b1, fd_en: 1'b1, dx_en: 1'b1, xm_en: 1'b1, mw_en: 1'b1,
          dx_bubble: 1'b0, fd_flush: 1'b0};
    return c;
  endfunction

  function automatic stage_ctrl_t ctrl_stop();
    stage_ctrl_t c;
    c = '0;
    return c;
  endfunction

  // The D/X register must be enabled so that the bubble is actually loaded;
  // only PC and F/D freeze, which keeps the stalled instruction in decode.
  function automatic stage_ctrl_t ctrl_hold();
    stage_ctrl_t c;
    c = '{pc_en: 1'b0, fd_en: 1'b0, dx_en: 1'b1, xm_en: 1'b1, mw_en: 1'b1,
          dx_bubble: 1'b1, fd_flush: 1'b0};
    return c;
  endfunction

  function automatic stage_ctrl_t ctrl_flush();
    stage_ctrl_t c;
    c = '{pc_en: 1'b1, fd_en: 1'b1, dx_en: 1'b1, xm_en: 1'b1, mw_en: 1'b1,
          dx_bubble: 1'b1, fd_flush: 1'b1};
    return c;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//
// Purpose : small up-counter with synchronous clear and count enable that
//           sticks at its all-ones value instead of wrapping. Used for the
//           memory-wait and load-stall cycle counters of the sequencer.
//           Asserting clr and en together loads 1, so a wait that starts in
//           the current cycle is already counted.
//
// Ports   :
//   clk    in   1      clock
//   reset  in   1      async reset, active-high, clears the count
//   clr    in   1      restart the count (0, or 1 when en is also high)
//   en     in   1      count one cycle
//   count  out  WIDTH  current count
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = 1;

  // Count register: restart on clr, otherwise step up until all ones and
  // then hold there so a long wait can never alias to a short one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= en ? ONE : '0;
    end else if (en && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl
//
// Purpose : central stall/flush sequencer for the 5-stage F/D/X/M/W pipeline.
//           It sits beside the forwarding logic and handles the cases that
//           forwarding cannot: load-use hazards, slow data memory, taken
//           branches and halt/resume requests. The state lives in a register;
//           every output is combinational from that state and the inputs.
//
// Parameters:
//   REG_AW       register-address width
//   LOAD_LAT     load-use stall cycles (1..7)
//   MEM_TIMEOUT  max memory-wait cycles before mem_err; 0 disables the timeout
//
// Ports   :
//   clk, reset        clock, async active-high reset
//   fd_rs_a, fd_rs_b  source registers of the instruction in F/D
//   dx_rd             destination register of the instruction in D/X
//   dx_is_load        D/X instruction is a load
//   br_taken_x        branch/jump taken, resolved in X this cycle
//   dmem_req          X/M stage issues a data-memory access
//   dmem_ack          data memory completes the access this cycle
//   halt_req          pulse: halt the pipeline
//   resume            pulse: leave HALT
//   pc_en, fd_en, dx_en, xm_en, mw_en   per-stage register enables
//   dx_bubble         D/X loads a NOP
//   fd_flush          F/D loads a NOP
//   mem_err           sticky memory-timeout flag, cleared only by reset
//   state_o           current sequencer state (debug)
//
// Build option:
//   PERF_CNT_EN  adds stall_cycles (cycles with pc_en low outside reset) and
//                flush_count (cycles with fd_flush high), both 32-bit wrapping.
// ---------------------------------------------------------------------------
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEF,
  parameter int LOAD_LAT    = 1,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] fd_rs_a,
  input  logic [REG_AW-1:0] fd_rs_b,
  input  logic [REG_AW-1:0] dx_rd,
  input  logic              dx_is_load,
  input  logic              br_taken_x,
  input  logic              dmem_req,
  input  logic              dmem_ack,
  input  logic              halt_req,
  input  logic              resume,
  output logic              pc_en,
  output logic              fd_en,
  output logic              dx_en,
  output logic              xm_en,
  output logic              mw_en,
  output logic              dx_bubble,
  output logic              fd_flush,
  output logic              mem_err,
  output logic [1:0]        state_o
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_count
`endif
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT) + 1;
  localparam int SCNT_W = $clog2(LOAD_LAT) + 1;

  localparam logic [WCNT_W-1:0] WCNT_LIMIT = WCNT_W'(MEM_TIMEOUT);
  localparam logic [SCNT_W-1:0] SCNT_LAST  = SCNT_W'(LOAD_LAT - 1);

  stall_state_e      state_q, state_d;
  logic              pending_q, pending_d;
  logic              err_q, err_d;
  logic [WCNT_W-1:0] wcnt;
  logic [SCNT_W-1:0] scnt;
  logic              w_clr, w_inc;
  logic              s_clr, s_inc;
  logic              load_use;
  logic              mem_stall;
  stage_ctrl_t       ctrl;
  stage_ctrl_t       ctrl_out;

  // Loads into r0 never produce a value anyone waits for, so they cannot
  // cause a load-use stall. A request acked in the same cycle is no wait.
  assign load_use  = dx_is_load && (dx_rd != '0) &&
                     ((dx_rd == fd_rs_a) || (dx_rd == fd_rs_b));
  assign mem_stall = dmem_req && !dmem_ack;

  sat_counter #(.WIDTH(WCNT_W)) u_wcnt (
    .clk   (clk),
    .reset (reset),
    .clr   (w_clr),
    .en    (w_inc),
    .count (wcnt)
  );

  sat_counter #(.WIDTH(SCNT_W)) u_scnt (
    .clk   (clk),
    .reset (reset),
    .clr   (s_clr),
    .en    (s_inc),
    .count (scnt)
  );

  // Next-state and output decode. In RUN the causes are ranked: a memory
  // stall freezes everything, a taken branch beats a load-use hazard because
  // the dependent instruction is on the wrong path anyway, and a halt request
  // only takes effect when nothing else is going on. A halt request arriving
  // while stalled is remembered and redirects the eventual return to RUN.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    err_d     = err_q;
    ctrl      = ctrl_advance();
    w_clr     = 1'b0;
    w_inc     = 1'b0;
    s_clr     = 1'b0;
    s_inc     = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_stall) begin
          ctrl    = ctrl_stop();
          state_d = MEM_WAIT;
          w_clr   = 1'b1;
          w_inc   = 1'b1;
        end else if (br_taken_x) begin
          ctrl = ctrl_flush();
        end else if (load_use) begin
          ctrl = ctrl_hold();
          if (LOAD_LAT > 1) begin
            state_d = LD_STALL;
            s_clr   = 1'b1;
            s_inc   = 1'b1;
          end
        end else if (halt_req) begin
          state_d = HALT;
        end
      end

      LD_STALL: begin
        ctrl  = ctrl_hold();
        s_inc = 1'b1;
        if (halt_req) begin
          pending_d = 1'b1;
        end
        if (scnt == SCNT_LAST) begin
          state_d = (pending_q || halt_req) ? HALT : RUN;
        end
      end

      MEM_WAIT: begin
        w_inc = 1'b1;
        if (halt_req) begin
          pending_d = 1'b1;
        end
        if (dmem_ack) begin
          ctrl    = ctrl_advance();
          state_d = (pending_q || halt_req) ? HALT : RUN;
        end else begin
          ctrl = ctrl_stop();
          if ((MEM_TIMEOUT != 0) && (wcnt == WCNT_LIMIT)) begin
            err_d   = 1'b1;
            state_d = HALT;
          end
        end
      end

      HALT: begin
        ctrl = ctrl_hold();
        if (resume) begin
          state_d   = RUN;
          pending_d = 1'b0;
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State, pending-halt and error registers. The error flag only ever sets;
  // it is cleared solely by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  // While reset is held every enable is low so no pipeline register can
  // capture anything, independent of what the decode above produces.
  assign ctrl_out  = reset ? ctrl_stop() : ctrl;

  assign pc_en     = ctrl_out.pc_en;
  assign fd_en     = ctrl_out.fd_en;
  assign dx_en     = ctrl_out.dx_en;
  assign xm_en     = ctrl_out.xm_en;
  assign mw_en     = ctrl_out.mw_en;
  assign dx_bubble = ctrl_out.dx_bubble;
  assign fd_flush  = ctrl_out.fd_flush;
  assign mem_err   = err_q;
  assign state_o   = state_q;

`ifdef PERF_CNT_EN
  // Performance counters: free-running, wrap naturally at 2^32. pc_en is
  // already forced low during reset, but the counters are held in reset
  // then, so those cycles are not counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_en) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (fd_flush) begin
        flush_count <= flush_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_stall_ctrl
//
// Two sequencers share one set of inputs: instance 0 with LOAD_LAT=1 and
// MEM_TIMEOUT=4, instance 1 with LOAD_LAT=3 and no timeout. Each cycle both
// are compared against a reference model that tracks "halted", "waiting on
// memory", "stall cycles still owed" and "halt pending" directly.
// ---------------------------------------------------------------------------
module tb_pipe_stall_ctrl;

  localparam int AW    = 5;
  localparam int LAT_0 = 1;
  localparam int TMO_0 = 4;
  localparam int LAT_1 = 3;
  localparam int TMO_1 = 0;

  // Control patterns, bit order {pc, fd, dx, xm, mw, bubble, flush}
  localparam logic [6:0] P_ADV   = 7'b1111100;
  localparam logic [6:0] P_HOLD  = 7'b0011110;
  localparam logic [6:0] P_FLUSH = 7'b1111111;
  localparam logic [6:0] P_STOP  = 7'b0000000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] fd_rs_a = '0, fd_rs_b = '0, dx_rd = '0;
  logic          dx_is_load = 1'b0, br_taken_x = 1'b0;
  logic          dmem_req = 1'b0, dmem_ack = 1'b0;
  logic          halt_req = 1'b0, resume = 1'b0;

  logic [1:0] pc_en, fd_en, dx_en, xm_en, mw_en, dx_bubble, fd_flush, mem_err;
  logic [1:0] state_o [2];
`ifdef PERF_CNT_EN
  logic [31:0] stall_cycles [2];
  logic [31:0] flush_count  [2];
`endif

  int n_compared   = 0;
  int n_mismatched = 0;
  int cyc          = 0;

  // Reference model state, one slot per instance
  bit m_halted [2];
  bit m_waiting[2];
  bit m_pending[2];
  bit m_err    [2];
  int m_wait_n [2];
  int m_stall  [2];

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.REG_AW(AW), .LOAD_LAT(LAT_0), .MEM_TIMEOUT(TMO_0)) dut0 (
    .clk(clk), .reset(reset),
    .fd_rs_a(fd_rs_a), .fd_rs_b(fd_rs_b), .dx_rd(dx_rd), .dx_is_load(dx_is_load),
    .br_taken_x(br_taken_x), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .halt_req(halt_req), .resume(resume),
    .pc_en(pc_en[0]), .fd_en(fd_en[0]), .dx_en(dx_en[0]), .xm_en(xm_en[0]),
    .mw_en(mw_en[0]), .dx_bubble(dx_bubble[0]), .fd_flush(fd_flush[0]),
    .mem_err(mem_err[0]), .state_o(state_o[0])
`ifdef PERF_CNT_EN
    , .stall_cycles(stall_cycles[0]), .flush_count(flush_count[0])
`endif
  );

  pipe_stall_ctrl #(.REG_AW(AW), .LOAD_LAT(LAT_1), .MEM_TIMEOUT(TMO_1)) dut1 (
    .clk(clk), .reset(reset),
    .fd_rs_a(fd_rs_a), .fd_rs_b(fd_rs_b), .dx_rd(dx_rd), .dx_is_load(dx_is_load),
    .br_taken_x(br_taken_x), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .halt_req(halt_req), .resume(resume),
    .pc_en(pc_en[1]), .fd_en(fd_en[1]), .dx_en(dx_en[1]), .xm_en(xm_en[1]),
    .mw_en(mw_en[1]), .dx_bubble(dx_bubble[1]), .fd_flush(fd_flush[1]),
    .mem_err(mem_err[1]), .state_o(state_o[1])
`ifdef PERF_CNT_EN
    , .stall_cycles(stall_cycles[1]), .flush_count(flush_count[1])
`endif
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s (cycle %0d): observed %h, required %h",
               tag, cyc, observed, expected);
    end
  endtask

  function automatic logic [9:0] observe(input int i);
    return {pc_en[i], fd_en[i], dx_en[i], xm_en[i], mw_en[i],
            dx_bubble[i], fd_flush[i], mem_err[i], state_o[i]};
  endfunction

  // Reference model: returns this cycle's expected outputs and advances
  // its bookkeeping to what should hold after the coming clock edge.
  task automatic model_step(input int i, input int lat, input int tmo,
                            output logic [9:0] exp);
    logic [6:0] ctl;
    logic [1:0] st;
    logic       err_now;
    bit         hazard;
    if (reset) begin
      m_halted[i] = 0; m_waiting[i] = 0; m_pending[i] = 0;
      m_err[i] = 0; m_wait_n[i] = 0; m_stall[i] = 0;
      exp = '0;
      return;
    end
    hazard  = dx_is_load && (dx_rd != 0) && (dx_rd == fd_rs_a || dx_rd == fd_rs_b);
    st      = m_halted[i] ? 2'd3 : m_waiting[i] ? 2'd2 : (m_stall[i] > 0) ? 2'd1 : 2'd0;
    err_now = m_err[i];
    ctl     = P_ADV;
    if (m_halted[i]) begin
      ctl = P_HOLD;
      if (resume) begin
        m_halted[i]  = 0;
        m_pending[i] = 0;
      end
    end else if (m_waiting[i]) begin
      if (halt_req) m_pending[i] = 1;
      if (dmem_ack) begin
        ctl = P_ADV;
        m_waiting[i] = 0;
        if (m_pending[i]) m_halted[i] = 1;
      end else begin
        ctl = P_STOP;
        if (tmo != 0 && m_wait_n[i] == tmo) begin
          m_err[i] = 1; m_waiting[i] = 0; m_halted[i] = 1;
        end else begin
          m_wait_n[i]++;
        end
      end
    end else if (m_stall[i] > 0) begin
      ctl = P_HOLD;
      if (halt_req) m_pending[i] = 1;
      m_stall[i]--;
      if (m_stall[i] == 0 && m_pending[i]) m_halted[i] = 1;
    end else begin
      if (dmem_req && !dmem_ack) begin
        ctl = P_STOP; m_waiting[i] = 1; m_wait_n[i] = 1;
      end else if (br_taken_x) begin
        ctl = P_FLUSH;
      end else if (hazard) begin
        ctl = P_HOLD; m_stall[i] = lat - 1;
      end else if (halt_req) begin
        m_halted[i] = 1;
      end
    end
    exp = {ctl, err_now, st};
  endtask

  // Drives one cycle of inputs just after the rising edge, then compares
  // both instances against the model while the inputs are stable.
  task automatic applyStimulus(input logic rst, input logic [AW-1:0] a,
                               input logic [AW-1:0] b, input logic [AW-1:0] rd,
                               input logic ld, input logic br, input logic req,
                               input logic ack, input logic hreq, input logic res);
    logic [9:0] exp;
    @(posedge clk);
    #1;
    cyc++;
    reset = rst; fd_rs_a = a; fd_rs_b = b; dx_rd = rd; dx_is_load = ld;
    br_taken_x = br; dmem_req = req; dmem_ack = ack; halt_req = hreq; resume = res;
    #1;
    model_step(0, LAT_0, TMO_0, exp);
    checkOutput("model dut0", {6'd0, observe(0)}, {6'd0, exp});
    model_step(1, LAT_1, TMO_1, exp);
    checkOutput("model dut1", {6'd0, observe(1)}, {6'd0, exp});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset with busy inputs: every output must stay at its reset value
    applyStimulus(1, 3, 3, 3, 1, 1, 1, 0, 1, 0);
    checkOutput("reset outputs", {6'd0, observe(0)}, 16'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("after reset", {11'd0, pc_en[0], fd_en[0], dx_en[0], xm_en[0], mw_en[0]}, 16'h1F);

    // Load r3 then use r3: one stall cycle with LOAD_LAT=1
    applyStimulus(0, 3, 1, 3, 1, 0, 0, 0, 0, 0);
    checkOutput("ld-use stall", {13'd0, pc_en[0], dx_bubble[0], xm_en[0]}, 16'b011);
    idle(1);
    checkOutput("ld-use release", {11'd0, pc_en[0], fd_en[0], dx_en[0], xm_en[0], mw_en[0]}, 16'h1F);
    idle(3);

    // Load r0 used by the next instruction: no stall
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("ld r0 no stall", {11'd0, pc_en[0], fd_en[0], dx_en[0], xm_en[0], mw_en[0]}, 16'h1F);

    // Memory wait, ack on the fourth cycle of the held request
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("mem wait state", {14'd0, state_o[0]}, 16'd2);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    checkOutput("mem ack enables", {11'd0, pc_en[0], fd_en[0], dx_en[0], xm_en[0], mw_en[0]}, 16'h1F);
    idle(1);
    checkOutput("mem back to run", {14'd0, state_o[0]}, 16'd0);

    // No ack: instance 0 times out after four wait cycles
    for (int k = 0; k < 6; k++) applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("timeout halt", {13'd0, mem_err[0], state_o[0]}, 16'b111);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    checkOutput("resume keeps err", {13'd0, mem_err[0], state_o[0]}, 16'b100);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(2);

    // Taken branch together with a load-use hazard: flush wins
    applyStimulus(0, 3, 0, 3, 1, 1, 0, 0, 0, 0);
    checkOutput("br over ld-use", {13'd0, fd_flush[0], dx_bubble[0], pc_en[0]}, 16'b111);
    idle(1);

    // Halt requested while waiting on memory, then ack
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    idle(1);
    checkOutput("pending halt", {14'd0, state_o[0]}, 16'd3);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset mid halt", {6'd0, observe(0)}, 16'd0);
    idle(2);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      applyStimulus((c % 700) == 699,
                    AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                    AW'($urandom_range(0, 7)),
                    $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0,
                    $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
